// File: rtl/adder_pkg.sv
// adder_pkg -- shared configuration for the pipelined ripple-carry adder.
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth
//   chunk_width()                  : bits handled per pipeline stage
//   config_ok()                    : elaboration-time legality check of WIDTH/STAGES
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 16;
    localparam int unsigned DEFAULT_STAGES = 4;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

    // The operand must split into equal chunks, one per stage.
    function automatic bit config_ok(input int unsigned width,
                                     input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_adder_rca_chunk.sv
// rca_chunk -- purely combinational W-bit ripple-carry adder slice.
//
// Ports:
//   a, b  : W-bit addends
//   cin   : carry into bit 0
//   sum   : W-bit sum
//   cout  : carry out of bit W-1
module rca_chunk
    import adder_pkg::*;
#(
    parameter int unsigned W = chunk_width(DEFAULT_WIDTH, DEFAULT_STAGES)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[W];

endmodule

// File: rtl/pipelined_rca_adder.sv
// pipelined_rca_adder -- WIDTH-bit add/subtract unit built as STAGES ripple
// chunks with the inter-chunk carry registered, valid/ready on both sides.
//
// {out_cout, out_sum} = in_a + (in_b ^ {WIDTH{in_sub}}) + (in_cin ^ in_sub)
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake; in_ready = ~stall
//   in_a, in_b          : operands
//   in_cin              : carry-in (borrow-in when subtracting)
//   in_sub              : 0 = add, 1 = subtract
//   out_valid/out_ready : result handshake
//   out_sum, out_cout   : result and carry-out (1 = no borrow on subtract)
//   out_ovf             : two's-complement overflow, only when SIGNED_OVF_EN
//                         is defined
//
// Optional feature macro: SIGNED_OVF_EN
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef SIGNED_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_cout
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (!config_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_rca_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    // Stage inputs (what stage k sees this cycle) and stage registers
    // (what stage k hands to stage k+1 on the next enabled edge).
    logic             stage_valid    [STAGES];
    logic             stage_carry    [STAGES];
    logic [WIDTH-1:0] stage_a        [STAGES];
    logic [WIDTH-1:0] stage_b        [STAGES];
    logic [WIDTH-1:0] stage_sum      [STAGES];
    logic [WIDTH-1:0] stage_sum_next [STAGES];
    logic             stage_cout     [STAGES];

    logic             valid_reg [STAGES];
    logic             carry_reg [STAGES];
    logic [WIDTH-1:0] sum_reg   [STAGES];
    logic [WIDTH-1:0] a_reg     [STAGES];
    logic [WIDTH-1:0] b_reg     [STAGES];

    logic stall;

    // One global enable: a held result freezes every stage, bubbles included.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [CHUNK-1:0] chunk_sum;
        logic [WIDTH-1:0] sum_merge;

        if (gi == 0) begin : g_head
            // Subtraction is A + ~B + ~borrow; the inversion happens once here.
            assign stage_valid[gi] = in_valid;
            assign stage_carry[gi] = in_cin ^ in_sub;
            assign stage_a[gi]     = in_a;
            assign stage_b[gi]     = in_b ^ {WIDTH{in_sub}};
            assign stage_sum[gi]   = '0;
        end else begin : g_body
            assign stage_valid[gi] = valid_reg[gi-1];
            assign stage_carry[gi] = carry_reg[gi-1];
            assign stage_a[gi]     = a_reg[gi-1];
            assign stage_b[gi]     = b_reg[gi-1];
            assign stage_sum[gi]   = sum_reg[gi-1];
        end

        rca_chunk #(
            .W (CHUNK)
        ) u_chunk (
            .a    (stage_a[gi][gi*CHUNK +: CHUNK]),
            .b    (stage_b[gi][gi*CHUNK +: CHUNK]),
            .cin  (stage_carry[gi]),
            .sum  (chunk_sum),
            .cout (stage_cout[gi])
        );

        // Lower chunks are already final; drop this stage's chunk in place.
        always_comb begin
            sum_merge                    = stage_sum[gi];
            sum_merge[gi*CHUNK +: CHUNK] = chunk_sum;
        end
        assign stage_sum_next[gi] = sum_merge;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg[gi] <= 1'b0;
                carry_reg[gi] <= 1'b0;
                sum_reg[gi]   <= '0;
                a_reg[gi]     <= '0;
                b_reg[gi]     <= '0;
            end else if (!stall) begin
                valid_reg[gi] <= stage_valid[gi];
                // Bubbles leave the data registers untouched to save toggling.
                if (stage_valid[gi]) begin
                    carry_reg[gi] <= stage_cout[gi];
                    sum_reg[gi]   <= stage_sum_next[gi];
                    a_reg[gi]     <= stage_a[gi];
                    b_reg[gi]     <= stage_b[gi];
                end
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_sum   = sum_reg[STAGES-1];
    assign out_cout  = carry_reg[STAGES-1];

`ifdef SIGNED_OVF_EN
    logic ovf_next;
    logic ovf_reg;

    // Carry-into-MSB XOR carry-out-of-MSB is equivalent to "operands share a
    // sign and the sum's sign differs", which needs no internal carry tap.
    assign ovf_next = (stage_a[STAGES-1][WIDTH-1] == stage_b[STAGES-1][WIDTH-1]) &&
                      (stage_sum_next[STAGES-1][WIDTH-1] != stage_a[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (!stall && stage_valid[STAGES-1]) begin
            ovf_reg <= ovf_next;
        end
    end

    assign out_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// tb_pipelined_rca_adder -- directed vectors with a scoreboard queue; the
// stimulus side pushes hand-computed results, a negedge monitor pops and
// compares every result the DUT hands over.
module tb_pipelined_rca_adder;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef SIGNED_OVF_EN
    logic         out_ovf;
`endif

    pipelined_rca_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef SIGNED_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks       = 0;
    int   passes       = 0;
    int   pushed_count = 0;
    int   results_seen = 0;
    int   retries      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: one compare set per handed-over result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            results_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(out_sum), 32'hDEAD_0000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("result #%0d: sum=0x%04h cout=%0b (required 0x%04h/%0b)",
                         results_seen, out_sum, out_cout, e.sum, e.cout);
                check("out_sum", 32'(out_sum), 32'(e.sum));
                check("out_cout", 32'(out_cout), 32'(e.cout));
`ifdef SIGNED_OVF_EN
                check("out_ovf", 32'(out_ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Drive at posedge+1; the beat is accepted by the next rising edge once
    // in_ready is seen high. Returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input bit push);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        #1;
        for (n = 0; n < 50 && !in_ready; n++) begin
            retries++;
            @(posedge clk);
            #2;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        if (push) begin
            exp_q.push_back('{sum: es, cout: ec, ovf: eo});
            pushed_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // The accepting edge counts as edge 1; out_valid must follow edge S.
    task automatic check_latency(input string name);
        int k;
        k = 1;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(k), 32'(S));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sum", 32'(out_sum), 32'd0);
        check("reset_out_cout", 32'(out_cout), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry crosses every stage; also measures first-beat latency
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        idle();
        check_latency("latency_first_beat");
        drain();

        // Subtract / borrow
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
        send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1);
        // Signed overflow corners and carry-in through a full carry chain
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1);
        send(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1);
        send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1);
        send(16'hABCD, 16'h5432, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        idle();
        drain();

        // Streaming: 8 back-to-back beats, A=i, B=0x1000*i -> sum 0x1001*i
        retries = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'(i), 16'(16'h1000 * i), 1'b0, 1'b0, 16'(16'h1001 * i), 1'b0, 1'b0, 1);
        end
        idle();
        check("stream_in_ready_stalls", 32'(retries), 32'd0);
        drain();

        // Backpressure: fill with out_ready low, hold 3 cycles, release
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b1, 16'h0E1E, 1'b1, 1'b0, 1);
        send(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1);
        idle();
        for (int c = 0; c < 3; c++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_sum_held", 32'(out_sum), 32'h3333);
            check("stall_out_cout_held", 32'(out_cout), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Reset mid-flight: three beats in flight are discarded
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
        send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 0);
        send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_out_sum", 32'(out_sum), 32'd0);
        check("async_reset_out_cout", 32'(out_cout), 32'd0);
        check("async_reset_in_ready", 32'(in_ready), 32'd1);
        #4;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        idle();
        check_latency("latency_after_reset");
        drain();

        repeat (4) @(posedge clk);
        #1;
        check("results_total", 32'(results_seen), 32'(pushed_count));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
